// File: rtl/booth_r4_mult_param.sv
// Parametrised radix-4 Booth sequential multiplier with signed/unsigned mode and go/done handshake.
// Optional multiply-accumulate build enabled by defining BOOTH_MAC_EN (adds the acc_clr input).
module booth_r4_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
`ifdef BOOTH_MAC_EN
  input  logic               acc_clr,
`endif
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int CW = $clog2(N + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_r4_mult_param: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [E-1:0]       acc_q, acc_d;
  logic [E-1:0]       mreg_q, mreg_d;
  logic [E-1:0]       mcand_q, mcand_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
`ifdef BOOTH_MAC_EN
  logic               acc_clr_q, acc_clr_d;
`endif

  logic [2:0]         digit;
  logic [E:0]         term;
  logic [E:0]         sum;
  logic [E-1:0]       acc_run;
  logic [E-1:0]       mreg_run;
  logic [2*WIDTH-1:0] result;
  logic [E-1:0]       mcand_ext;
  logic [E-1:0]       mplier_ext;

  // Operands are widened by two bits so unsigned values stay positive under signed recoding.
  always_comb begin
    mcand_ext  = signed_mode ? {{2{mcand[WIDTH-1]}}, mcand}   : {2'b00, mcand};
    mplier_ext = signed_mode ? {{2{mplier[WIDTH-1]}}, mplier} : {2'b00, mplier};
  end

  always_comb begin
    digit = {mreg_q[1:0], qm1_q};
    term  = '0;
    unique case (digit)
      3'b001, 3'b010: term = {mcand_q[E-1], mcand_q};
      3'b011:         term = {mcand_q, 1'b0};
      3'b100:         term = -{mcand_q, 1'b0};
      3'b101, 3'b110: term = -{mcand_q[E-1], mcand_q};
      default:        term = '0;
    endcase
    sum      = {acc_q[E-1], acc_q} + term;
    // Arithmetic shift of {sum, mreg, q(-1)} by two; acc keeps E bits, the spare sign bit folds in.
    acc_run  = {sum[E], sum[E:2]};
    mreg_run = {sum[1:0], mreg_q[E-1:2]};
    result   = {acc_run[E-5:0], mreg_run};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    mreg_d    = mreg_q;
    mcand_d   = mcand_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef BOOTH_MAC_EN
    acc_clr_d = acc_clr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          acc_d     = '0;
          mreg_d    = mplier_ext;
          mcand_d   = mcand_ext;
          qm1_d     = 1'b0;
          cnt_d     = CW'(N);
`ifdef BOOTH_MAC_EN
          acc_clr_d = acc_clr;
`endif
        end
      end
      S_RUN: begin
        acc_d  = acc_run;
        mreg_d = mreg_run;
        qm1_d  = mreg_q[1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef BOOTH_MAC_EN
          product_d = (acc_clr_q ? '0 : product_q) + result;
`else
          product_d = result;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      mreg_q    <= '0;
      mcand_q   <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef BOOTH_MAC_EN
      acc_clr_q <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      mreg_q    <= mreg_d;
      mcand_q   <= mcand_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef BOOTH_MAC_EN
      acc_clr_q <= acc_clr_d;
`endif
    end
  end

  assign product = product_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign state   = state_q;

endmodule

// File: tb/tb_booth_r4_mult_param.sv
// Directed self-checking bench for booth_r4_mult_param at WIDTH=8.
module tb_booth_r4_mult_param;

  logic        clk;
  logic        rst;
  logic        go;
  logic        signed_mode;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic [1:0]  state;
`ifdef BOOTH_MAC_EN
  logic        acc_clr;
`endif

  int unsigned n_cmp;
  int unsigned n_err;
  logic [15:0] last_prod;

  booth_r4_mult_param #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .signed_mode (signed_mode),
    .mcand       (mcand),
    .mplier      (mplier),
`ifdef BOOTH_MAC_EN
    .acc_clr     (acc_clr),
`endif
    .product     (product),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start one multiplication, then follow it through RUN to DONE and back to IDLE.
  task automatic mult(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string tag);
    int unsigned busy_cyc;
    bit          got;
    busy_cyc = 0;
    got      = 1'b0;
    @(negedge clk);
    signed_mode = sm;
    mcand       = a;
    mplier      = b;
    go          = 1'b1;
    @(negedge clk);
    go     = 1'b0;
    mcand  = 8'h5A;
    mplier = 8'hA5;
    check({tag, "_state_run"}, 32'(state), 32'h1);
    check({tag, "_prod_hold"}, 32'(product), 32'(last_prod));
    for (int unsigned i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cyc++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'h1);
    check({tag, "_busy_cyc"}, busy_cyc, 32'd5);
    check({tag, "_product"}, 32'(product), 32'(exp));
    check({tag, "_busy_in_done"}, 32'(busy), 32'h0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    check({tag, "_state_idle"}, 32'(state), 32'h0);
    last_prod = exp;
  endtask

  initial begin
    int unsigned dcnt;
    n_cmp       = 0;
    n_err       = 0;
    last_prod   = '0;
    rst         = 1'b0;
    go          = 1'b0;
    signed_mode = 1'b0;
    mcand       = '0;
    mplier      = '0;
`ifdef BOOTH_MAC_EN
    acc_clr     = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check("rst_product", 32'(product), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_hold", 32'(state), 32'h0);

    mult(1'b1, 8'd45, 8'd21, 16'h03B1, "s45x21");
    mult(1'b1, 8'h80, 8'h80, 16'h4000, "sm128xm128");
    mult(1'b1, 8'hF9, 8'h05, 16'hFFDD, "sm7x5");
    mult(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u255x255");
    mult(1'b1, 8'hFF, 8'hFF, 16'h0001, "sm1xm1");
    mult(1'b1, 8'h7F, 8'h80, 16'hC080, "s127xm128");
    mult(1'b0, 8'd200, 8'd3, 16'h0258, "u200x3");
    mult(1'b0, 8'h00, 8'hFF, 16'h0000, "u0x255");

    // go held high through RUN with changing operands
    @(negedge clk);
    signed_mode = 1'b1;
    mcand       = 8'd45;
    mplier      = 8'd21;
    go          = 1'b1;
    @(negedge clk);
    mcand  = 8'd3;
    mplier = 8'd4;
    dcnt   = 0;
    while (!done && dcnt < 20) begin
      @(negedge clk);
      dcnt++;
    end
    check("hold_go_done_cyc", dcnt, 32'd5);
    check("hold_go_product", 32'(product), 32'h03B1);
    @(negedge clk);
    check("hold_go_idle", 32'(state), 32'h0);
    @(negedge clk);
    check("hold_go_restart", 32'(state), 32'h1);
    go   = 1'b0;
    dcnt = 0;
    while (!done && dcnt < 20) begin
      @(negedge clk);
      dcnt++;
    end
    check("hold_go_second", 32'(product), 32'h000C);
    @(negedge clk);
    last_prod = 16'h000C;

    // reset during the third RUN cycle
    @(negedge clk);
    signed_mode = 1'b1;
    mcand       = 8'd45;
    mplier      = 8'd21;
    go          = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_product", 32'(product), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_state", 32'(state), 32'h0);
    @(negedge clk);
    rst  = 1'b1;
    dcnt = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 32'd0);
    last_prod = 16'h0000;
    mult(1'b1, 8'd3, 8'd4, 16'h000C, "post_rst_3x4");

`ifdef BOOTH_MAC_EN
    acc_clr = 1'b1;
    mult(1'b0, 8'd3, 8'd4, 16'h000C, "mac_clr_3x4");
    acc_clr = 1'b0;
    mult(1'b0, 8'd5, 8'd6, 16'h002A, "mac_acc_5x6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
